// File: rtl/legv8_pkg.sv
// -----------------------------------------------------------------------------
// legv8_pkg
// Shared definitions for the LEGv8 instruction encoder (program loader).
// The opcode constants here are the same ones the control decoder matches on.
// Contents:
//   - op_e         : symbolic operation codes accepted on the host interface
//   - OPC_*        : 11/10/8/6-bit architectural opcode fields
//   - field widths : op, register, immediate and word widths
//   - HALT_WORD    : reserved all-ones word that marks end of program
//   - enc_state_e  : loader FSM states
//   - imm_fits_signed : two's-complement range test used by the optional
//                       immediate range check (ENC_RANGE_CHECK_EN)
// -----------------------------------------------------------------------------
package legv8_pkg;

  localparam int OP_W   = 4;
  localparam int REG_W  = 5;
  localparam int IMM_W  = 26;
  localparam int WORD_W = 32;

  typedef enum logic [OP_W-1:0] {
    OP_LDUR = 4'd0,
    OP_STUR = 4'd1,
    OP_ADD  = 4'd2,
    OP_ADDI = 4'd3,
    OP_SUB  = 4'd4,
    OP_AND  = 4'd5,
    OP_ORR  = 4'd6,
    OP_CBZ  = 4'd7,
    OP_CBNZ = 4'd8,
    OP_B    = 4'd9,
    OP_HALT = 4'd10
  } op_e;

  // R-format and D-format 11-bit opcodes
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  // I-format 10-bit opcode
  localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
  // CB-format 8-bit opcodes
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  localparam logic [7:0]  OPC_CBNZ = 8'b10110101;
  // B-format 6-bit opcode
  localparam logic [5:0]  OPC_B    = 6'b000101;

  localparam logic [WORD_W-1:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } enc_state_e;

  // True when imm, read as a 26-bit two's-complement value, is representable
  // in a signed field of the given width (all bits above the field's sign bit
  // are copies of it).
  function automatic logic imm_fits_signed(input logic [IMM_W-1:0] imm,
                                           input int width);
    logic [IMM_W-1:0] hi_mask;
    hi_mask = ~((IMM_W'(1) << (width - 1)) - IMM_W'(1));
    return ((imm & hi_mask) == '0) || ((imm & hi_mask) == hi_mask);
  endfunction

endpackage

// File: rtl/legv8_encode.sv
// -----------------------------------------------------------------------------
// legv8_encode
// Purely combinational encoder: symbolic {op, fields} -> 32-bit LEGv8 word.
// Ports:
//   i_op        in  4   symbolic operation (op_e); 11..15 are illegal
//   i_rd        in  5   Rd / Rt
//   i_rn        in  5   Rn
//   i_rm        in  5   Rm (R-format only)
//   i_imm       in  26  immediate (ADDI unsigned, others two's-complement)
//   o_word      out 32  encoded instruction word (0 for illegal ops)
//   o_illegal   out 1   op code outside the supported set
//   o_range_err out 1   immediate does not fit its field
// Configuration macro: ENC_RANGE_CHECK_EN. When undefined, immediates are
// truncated to the field width and o_range_err is tied low.
// -----------------------------------------------------------------------------
module legv8_encode
  import legv8_pkg::*;
(
  input  logic [OP_W-1:0]   i_op,
  input  logic [REG_W-1:0]  i_rd,
  input  logic [REG_W-1:0]  i_rn,
  input  logic [REG_W-1:0]  i_rm,
  input  logic [IMM_W-1:0]  i_imm,
  output logic [WORD_W-1:0] o_word,
  output logic              o_illegal,
  output logic              o_range_err
);

  always_comb begin
    o_word      = '0;
    o_illegal   = 1'b0;
    o_range_err = 1'b0;
    case (op_e'(i_op))
      OP_LDUR, OP_STUR: begin
        o_word = {(op_e'(i_op) == OP_LDUR) ? OPC_LDUR : OPC_STUR,
                  i_imm[8:0], 2'b00, i_rn, i_rd};
`ifdef ENC_RANGE_CHECK_EN
        o_range_err = !imm_fits_signed(i_imm, 9);
`endif
      end
      OP_ADD:  o_word = {OPC_ADD, i_rm, 6'b0, i_rn, i_rd};
      OP_SUB:  o_word = {OPC_SUB, i_rm, 6'b0, i_rn, i_rd};
      OP_AND:  o_word = {OPC_AND, i_rm, 6'b0, i_rn, i_rd};
      OP_ORR:  o_word = {OPC_ORR, i_rm, 6'b0, i_rn, i_rd};
      OP_ADDI: begin
        o_word = {OPC_ADDI, i_imm[11:0], i_rn, i_rd};
`ifdef ENC_RANGE_CHECK_EN
        // ADDI immediate is unsigned 0..4095
        o_range_err = |i_imm[IMM_W-1:12];
`endif
      end
      OP_CBZ, OP_CBNZ: begin
        o_word = {(op_e'(i_op) == OP_CBZ) ? OPC_CBZ : OPC_CBNZ,
                  i_imm[18:0], i_rd};
`ifdef ENC_RANGE_CHECK_EN
        o_range_err = !imm_fits_signed(i_imm, 19);
`endif
      end
      // imm26 uses the whole input, so it can never be out of range
      OP_B:    o_word = {OPC_B, i_imm};
      OP_HALT: o_word = HALT_WORD;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/legv8_inst_encoder.sv
// -----------------------------------------------------------------------------
// legv8_inst_encoder
// Program loader: accepts symbolic LEGv8 instructions over valid/ready,
// encodes them and writes the words to instruction memory at consecutive
// addresses from 0 until HALT is written or the memory is full.
// Parameters:
//   ADDR_W     word-address width, DEPTH = 2**ADDR_W
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   start                 begin a load session (only honoured in IDLE)
//   in_valid / in_ready   instruction handshake; in_ready == state LOAD
//   in_op, in_rd, in_rn, in_rm, in_imm   instruction fields
//   mem_we, mem_addr, mem_wdata          registered memory write port
//   busy                  session active
//   done                  one-cycle pulse with the final write of a session
//   err                   sticky error (illegal op, range, overflow)
//   count                 words written this/last session (saturates at DEPTH)
// Configuration macro: ENC_RANGE_CHECK_EN (out-of-range immediates dropped
// and flagged instead of truncated).
// -----------------------------------------------------------------------------
module legv8_inst_encoder
  import legv8_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [REG_W-1:0]  in_rn,
  input  logic [REG_W-1:0]  in_rm,
  input  logic [IMM_W-1:0]  in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam int DEPTH = 2 ** ADDR_W;

  enc_state_e        r_state, w_state_next;
  logic [ADDR_W-1:0] r_ptr, w_ptr_next;
  logic [ADDR_W:0]   r_count, w_count_next;
  logic              r_err, w_err_next;
  logic              r_mem_we, w_mem_we_next;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_next;
  logic [WORD_W-1:0] r_mem_wdata, w_mem_wdata_next;
  logic              r_done, w_done_next;

  logic [WORD_W-1:0] w_word;
  logic              w_illegal;
  logic              w_range_err;
  logic              w_xfer;

  legv8_encode u_encode (
    .i_op        (in_op),
    .i_rd        (in_rd),
    .i_rn        (in_rn),
    .i_rm        (in_rm),
    .i_imm       (in_imm),
    .o_word      (w_word),
    .o_illegal   (w_illegal),
    .o_range_err (w_range_err)
  );

  assign w_xfer = in_valid && (r_state == ST_LOAD);

  always_comb begin
    w_state_next     = r_state;
    w_ptr_next       = r_ptr;
    w_count_next     = r_count;
    w_err_next       = r_err;
    w_mem_we_next    = 1'b0;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    w_done_next      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_LOAD;
          w_ptr_next   = '0;
          w_count_next = '0;
          w_err_next   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (w_xfer) begin
          if (w_illegal || w_range_err) begin
            // word is consumed but discarded; pointer stays put
            w_err_next = 1'b1;
          end else begin
            w_mem_we_next    = 1'b1;
            w_mem_addr_next  = r_ptr;
            w_mem_wdata_next = w_word;
            w_ptr_next       = r_ptr + ADDR_W'(1);
            if (r_count != (ADDR_W+1)'(DEPTH)) begin
              w_count_next = r_count + (ADDR_W+1)'(1);
            end
            if (op_e'(in_op) == OP_HALT) begin
              w_state_next = ST_IDLE;
              w_done_next  = 1'b1;
            end else if (&r_ptr) begin
              // last slot filled without a HALT: program overflowed memory
              w_state_next = ST_IDLE;
              w_done_next  = 1'b1;
              w_err_next   = 1'b1;
            end
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_count     <= '0;
      r_err       <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_ptr       <= w_ptr_next;
      r_count     <= w_count_next;
      r_err       <= w_err_next;
      r_mem_we    <= w_mem_we_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
      r_done      <= w_done_next;
    end
  end

  // A reset arriving in the cycle a write is presented suppresses the strobe,
  // so the memory never commits a word from an aborted session.
  assign mem_we    = r_mem_we && !reset;
  assign done      = r_done && !reset;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign in_ready  = (r_state == ST_LOAD);
  assign busy      = (r_state == ST_LOAD);
  assign err       = r_err;
  assign count     = r_count;

endmodule

// File: tb/tb_legv8_inst_encoder.sv
// -----------------------------------------------------------------------------
// tb_legv8_inst_encoder
// Self-checking bench for legv8_inst_encoder (ADDR_W = 2, DEPTH = 4).
// Table of known encodings, hand-written session sequences (HALT, overflow,
// illegal op, immediate range, reset abort) and randomized sessions checked
// against a reference model built from the instruction-format arithmetic.
// Honors ENC_RANGE_CHECK_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_legv8_inst_encoder;

  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [4:0]    in_rd, in_rn, in_rm;
  logic [25:0]   in_imm;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy, done, err;
  logic [AW:0]   count;

  always #5 clk = ~clk;

  legv8_inst_encoder #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_rn     (in_rn),
    .in_rm     (in_rm),
    .in_imm    (in_imm),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .count     (count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, let the rising edge happen, return at the
  // following negedge with the registered results visible.
  task automatic tick(input logic s, input logic v, input logic [3:0] op,
                      input logic [4:0] rd, input logic [4:0] rn,
                      input logic [4:0] rm, input logic [25:0] imm);
    start = s; in_valid = v; in_op = op;
    in_rd = rd; in_rn = rn; in_rm = rm; in_imm = imm;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    $display("txn start=%0b valid=%0b op=%0d rd=%0d rn=%0d rm=%0d imm=%07h -> we=%0b addr=%0d data=%08h done=%0b err=%0b cnt=%0d rdy=%0b",
             s, v, op, rd, rn, rm, imm, mem_we, mem_addr, mem_wdata, done, err, count, in_ready);
  endtask

  task automatic do_start();
    tick(1'b1, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 26'd0);
  endtask

  task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                      input logic [4:0] rm, input logic [25:0] imm);
    tick(1'b0, 1'b1, op, rd, rn, rm, imm);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_word(input int op, input longint rd, input longint rn,
                                           input longint rm, input longint imm);
    longint w;
    case (op)
      0:  w = 64'h7C2 * (64'd1 << 21) + (imm % 512) * 4096 + rn * 32 + rd;
      1:  w = 64'h7C0 * (64'd1 << 21) + (imm % 512) * 4096 + rn * 32 + rd;
      2:  w = 64'h458 * (64'd1 << 21) + rm * 65536 + rn * 32 + rd;
      4:  w = 64'h658 * (64'd1 << 21) + rm * 65536 + rn * 32 + rd;
      5:  w = 64'h450 * (64'd1 << 21) + rm * 65536 + rn * 32 + rd;
      6:  w = 64'h550 * (64'd1 << 21) + rm * 65536 + rn * 32 + rd;
      3:  w = 64'h244 * (64'd1 << 22) + (imm % 4096) * 1024 + rn * 32 + rd;
      7:  w = 64'hB4 * (64'd1 << 24) + (imm % (64'd1 << 19)) * 32 + rd;
      8:  w = 64'hB5 * (64'd1 << 24) + (imm % (64'd1 << 19)) * 32 + rd;
      9:  w = 5 * (64'd1 << 26) + imm;
      default: w = 64'hFFFF_FFFF;
    endcase
    return w[31:0];
  endfunction

  function automatic bit ref_imm_ok(input int op, input longint imm);
    longint s;
    s = (imm >= 64'd33554432) ? imm - 64'd67108864 : imm;
    case (op)
      3:       return imm < 4096;
      0, 1:    return (s >= -256) && (s <= 255);
      7, 8:    return (s >= -262144) && (s <= 262143);
      default: return 1'b1;
    endcase
  endfunction

  bit m_active;
  int m_ptr;
  int m_count;
  bit m_err;

  task automatic model_send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                            input logic [4:0] rm, input logic [25:0] imm);
    int          iop;
    bit          ok;
    bit          exp_we;
    bit          exp_done;
    int          exp_addr;
    logic [31:0] exp_data;
    iop = int'(op);
    ok = (iop <= 10);
`ifdef ENC_RANGE_CHECK_EN
    if (ok) ok = ref_imm_ok(iop, longint'(imm));
`endif
    exp_we = 1'b0; exp_done = 1'b0; exp_addr = 0; exp_data = 32'd0;
    if (ok) begin
      exp_we   = 1'b1;
      exp_addr = m_ptr;
      exp_data = ref_word(iop, longint'(rd), longint'(rn), longint'(rm), longint'(imm));
      if (m_count < DEPTH) m_count++;
      if (iop == 10) begin
        m_active = 1'b0; exp_done = 1'b1;
      end else if (m_ptr == DEPTH - 1) begin
        m_active = 1'b0; exp_done = 1'b1; m_err = 1'b1;
      end
      m_ptr++;
    end else begin
      m_err = 1'b1;
    end
    send(op, rd, rn, rm, imm);
    check("rnd_we", 32'(mem_we), 32'(exp_we));
    if (exp_we) begin
      check("rnd_addr", 32'(mem_addr), 32'(exp_addr));
      check("rnd_data", mem_wdata, exp_data);
    end
    check("rnd_done", 32'(done), 32'(exp_done));
    check("rnd_err", 32'(err), 32'(m_err));
    check("rnd_count", 32'(count), 32'(m_count));
    check("rnd_ready", 32'(in_ready), 32'(m_active));
  endtask

  // ---------------- known-encoding table ----------------
  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rd, rn, rm;
    logic [25:0] imm;
    logic [31:0] word;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{op: 4'd2, rd: 5'd1, rn: 5'd2,  rm: 5'd3,  imm: 26'h155,     word: 32'h8B03_0041}; // ADD
    vecs[1] = '{op: 4'd0, rd: 5'd9, rn: 5'd10, rm: 5'd17, imm: 26'h3FFFFF8, word: 32'hF85F_8149}; // LDUR -8
    vecs[2] = '{op: 4'd3, rd: 5'd5, rn: 5'd5,  rm: 5'd31, imm: 26'd1,       word: 32'h9100_04A5}; // ADDI 1
    vecs[3] = '{op: 4'd7, rd: 5'd3, rn: 5'd9,  rm: 5'd4,  imm: 26'h3FFFFFE, word: 32'hB4FF_FFC3}; // CBZ -2
    vecs[4] = '{op: 4'd9, rd: 5'd7, rn: 5'd6,  rm: 5'd5,  imm: 26'd4,       word: 32'h1400_0004}; // B 4

    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    in_op = 4'd0; in_rd = 5'd0; in_rn = 5'd0; in_rm = 5'd0; in_imm = 26'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // reset state
    check("rst_we",    32'(mem_we),    32'd0);
    check("rst_addr",  32'(mem_addr),  32'd0);
    check("rst_wdata", mem_wdata,      32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_done",  32'(done),      32'd0);
    check("rst_err",   32'(err),       32'd0);
    check("rst_count", 32'(count),     32'd0);
    check("rst_ready", 32'(in_ready),  32'd0);

    // table: each vector alone in a session, closed by HALT
    for (int i = 0; i < 5; i++) begin
      do_start();
      check("tbl_ready", 32'(in_ready), 32'd1);
      send(vecs[i].op, vecs[i].rd, vecs[i].rn, vecs[i].rm, vecs[i].imm);
      check("tbl_we",   32'(mem_we),   32'd1);
      check("tbl_addr", 32'(mem_addr), 32'd0);
      check("tbl_data", mem_wdata,     vecs[i].word);
      send(4'd10, 5'd0, 5'd0, 5'd0, 26'd0);
      check("tbl_halt_done",  32'(done),     32'd1);
      check("tbl_halt_addr",  32'(mem_addr), 32'd1);
      check("tbl_halt_count", 32'(count),    32'd2);
      check("tbl_halt_ready", 32'(in_ready), 32'd0);
    end

    // three words then HALT in the last slot; start during LOAD is ignored
    do_start();
    send(4'd2, 5'd1, 5'd2, 5'd3, 26'd0);
    check("seq_addr0", 32'(mem_addr), 32'd0);
    tick(1'b1, 1'b1, 4'd4, 5'd4, 5'd5, 5'd6, 26'd0);
    check("seq_addr1", 32'(mem_addr), 32'd1);
    check("seq_sub",   mem_wdata,     32'hCB06_00A4);
    check("seq_cnt1",  32'(count),    32'd2);
    send(4'd6, 5'd7, 5'd8, 5'd9, 26'd0);
    check("seq_addr2", 32'(mem_addr), 32'd2);
    check("seq_orr",   mem_wdata,     32'hAA09_0107);
    check("seq_done2", 32'(done),     32'd0);
    send(4'd10, 5'd0, 5'd0, 5'd0, 26'd0);
    check("seq_halt_we",   32'(mem_we),   32'd1);
    check("seq_halt_addr", 32'(mem_addr), 32'd3);
    check("seq_halt_data", mem_wdata,     32'hFFFF_FFFF);
    check("seq_halt_done", 32'(done),     32'd1);
    check("seq_halt_err",  32'(err),      32'd0);
    check("seq_halt_cnt",  32'(count),    32'd4);
    check("seq_halt_rdy",  32'(in_ready), 32'd0);
    check("seq_halt_busy", 32'(busy),     32'd0);
    send(4'd2, 5'd1, 5'd1, 5'd1, 26'd0);
    check("idle_no_we",  32'(mem_we), 32'd0);
    check("idle_cnt",    32'(count),  32'd4);

    // ADDI with an immediate one past the field
    do_start();
    send(4'd3, 5'd5, 5'd5, 5'd0, 26'd4096);
`ifdef ENC_RANGE_CHECK_EN
    check("addi_rng_we",  32'(mem_we),   32'd0);
    check("addi_rng_err", 32'(err),      32'd1);
    check("addi_rng_rdy", 32'(in_ready), 32'd1);
    send(4'd2, 5'd1, 5'd2, 5'd3, 26'd0);
    check("addi_rng_next_addr", 32'(mem_addr), 32'd0);
    check("addi_rng_next_we",   32'(mem_we),   32'd1);
`else
    check("addi_trunc_we",   32'(mem_we),   32'd1);
    check("addi_trunc_data", mem_wdata,     32'h9100_00A5);
    check("addi_trunc_err",  32'(err),      32'd0);
    send(4'd2, 5'd1, 5'd2, 5'd3, 26'd0);
    check("addi_trunc_next_addr", 32'(mem_addr), 32'd1);
`endif
    send(4'd10, 5'd0, 5'd0, 5'd0, 26'd0);
    check("addi_halt_done", 32'(done), 32'd1);

    // overflow: four non-HALT words fill the memory
    do_start();
    for (int k = 0; k < 4; k++) begin
      send(4'd5, 5'(k), 5'd1, 5'd2, 26'd0);
      check("full_addr", 32'(mem_addr), 32'(k));
      check("full_done", 32'(done),     (k == 3) ? 32'd1 : 32'd0);
      check("full_err",  32'(err),      (k == 3) ? 32'd1 : 32'd0);
    end
    check("full_ready", 32'(in_ready), 32'd0);
    check("full_count", 32'(count),    32'd4);

    // illegal op: dropped, err set, pointer unchanged
    do_start();
    check("ill_err_cleared", 32'(err), 32'd0);
    send(4'd12, 5'd1, 5'd2, 5'd3, 26'd0);
    check("ill_we",    32'(mem_we),   32'd0);
    check("ill_err",   32'(err),      32'd1);
    check("ill_ready", 32'(in_ready), 32'd1);
    send(4'd10, 5'd0, 5'd0, 5'd0, 26'd0);
    check("ill_halt_addr", 32'(mem_addr), 32'd0);
    check("ill_halt_cnt",  32'(count),    32'd1);
    check("ill_halt_err",  32'(err),      32'd1);

    // reset in the cycle after a handshake cancels the pending write
    do_start();
    send(4'd2, 5'd1, 5'd2, 5'd3, 26'd0);
    in_valid = 1'b1; in_op = 4'd4; in_rd = 5'd1; in_rn = 5'd1; in_rm = 5'd1;
    @(posedge clk);
    #1;
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("rstmid_we",   32'(mem_we), 32'd0);
    check("rstmid_done", 32'(done),   32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_addr",  32'(mem_addr), 32'd0);
    check("rstmid_wdata", mem_wdata,     32'd0);
    check("rstmid_busy",  32'(busy),     32'd0);
    check("rstmid_count", 32'(count),    32'd0);
    check("rstmid_ready", 32'(in_ready), 32'd0);
    do_start();
    send(4'd2, 5'd1, 5'd2, 5'd3, 26'd0);
    check("rstmid_re_addr", 32'(mem_addr), 32'd0);
    check("rstmid_re_data", mem_wdata,     32'h8B03_0041);
    check("rstmid_re_cnt",  32'(count),    32'd1);
    send(4'd10, 5'd0, 5'd0, 5'd0, 26'd0);

    // randomized sessions against the reference model
    for (int s = 0; s < 40; s++) begin
      do_start();
      m_active = 1'b1; m_ptr = 0; m_count = 0; m_err = 1'b0;
      check("rnd_start_ready", 32'(in_ready), 32'd1);
      check("rnd_start_err",   32'(err),      32'd0);
      for (int k = 0; k < 12 && m_active; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          tick(1'b0, 1'b0, 4'd2, 5'd0, 5'd0, 5'd0, 26'd0);
          check("rnd_idle_we", 32'(mem_we), 32'd0);
        end else begin
          logic [25:0] imm;
          case ($urandom_range(0, 3))
            0:       imm = 26'($urandom);
            1:       imm = 26'($urandom_range(0, 600)) - 26'd300;
            2:       imm = 26'($urandom_range(0, 5000));
            default: imm = 26'($urandom_range(0, 524288)) - 26'd262144;
          endcase
          model_send(4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom),
                     5'($urandom), imm);
        end
      end
      if (m_active) model_send(4'd10, 5'd0, 5'd0, 5'd0, 26'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
